// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and instruction field positions for the decode stage
package pipe_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 4;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 0;
  localparam int RD_LSB  = 12;
  localparam int IMM24_W = 24;
  localparam int IMM12_W = 12;
  localparam int IMM8_W  = 8;
endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: register array with two async read ports, one sync write port and write-to-read bypass
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              w_ok;

  assign w_ok = we && (int'(waddr) < NUM_REGS);

  // Clear on reset, otherwise commit in-range writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (w_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle writeback wins over stored data; out-of-range reads give 0
  always_comb begin
    rdata_a = (w_ok && waddr == raddr_a) ? wdata :
              (int'(raddr_a) < NUM_REGS) ? mem[raddr_a] : '0;
    rdata_b = (w_ok && waddr == raddr_b) ? wdata :
              (int'(raddr_b) < NUM_REGS) ? mem[raddr_b] : '0;
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decodes an instruction, reads operands, extends immediates and latches results
module decode_stage_pipe import pipe_pkg::*; #(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int REG_AW   = pipe_pkg::REG_AW,
  parameter int NUM_REGS = 16,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              r_write,
  input  logic [REG_AW-1:0] rd_write,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] dataA_out,
  output logic [DATA_W-1:0] dataB_out,
  output logic [DATA_W-1:0] br_se_out,
  output logic [DATA_W-1:0] ls_se_out,
  output logic [DATA_W-1:0] alu_se_out,
  output logic [REG_AW-1:0] rd_out
);
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] data_a, data_b, br_ext, br_se, ls_se, alu_se;
  logic              unused_hi;

  assign unused_hi = ^instruction[31:IMM24_W];
  assign in_ready  = !stall;

  // Field split and immediate extension
  always_comb begin
    rs     = instruction[RS_LSB +: REG_AW];
    rt     = instruction[RT_LSB +: REG_AW];
    rd     = instruction[RD_LSB +: REG_AW];
    br_ext = {{(DATA_W-IMM24_W){instruction[IMM24_W-1]}}, instruction[IMM24_W-1:0]};
    br_se  = br_ext << BR_SHIFT;
    ls_se  = {{(DATA_W-IMM12_W){instruction[IMM12_W-1]}}, instruction[IMM12_W-1:0]};
    alu_se = {{(DATA_W-IMM8_W){1'b0}}, instruction[IMM8_W-1:0]};
  end

  regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (r_write),
    .waddr   (rd_write),
    .wdata   (data_in),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (data_a),
    .rdata_b (data_b)
  );

  // Output latch: flush bubbles, stall holds, otherwise load decoded values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      pc_out     <= '0;
      dataA_out  <= '0;
      dataB_out  <= '0;
      br_se_out  <= '0;
      ls_se_out  <= '0;
      alu_se_out <= '0;
      rd_out     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (!stall) begin
      out_valid  <= in_valid;
      pc_out     <= pc_in;
      dataA_out  <= data_a;
      dataB_out  <= data_b;
      br_se_out  <= br_se;
      ls_se_out  <= ls_se;
      alu_se_out <= alu_se;
      rd_out     <= rd;
    end
  end
endmodule
